// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle datapath controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_REGA   = 2'b01;
  localparam logic [1:0] SRC_B_REGB   = 2'b00;
  localparam logic [1:0] SRC_B_ONE    = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  function automatic logic is_rtype(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_JMP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ALU operation select from FSM state and the latched opcode.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode_q,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    if (state == StExec) begin
      if (is_rtype(opcode_q)) begin
        alu_op = {1'b0, opcode_q[1:0]};
      end else if (opcode_q == OP_BEQ) begin
        alu_op = ALU_SUB;
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM sequencing fetch/decode/execute/memory/write-back, one instruction at a time.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a_sel,
  output logic [1:0] alu_src_b_sel,
  output logic [1:0] pc_src_sel,
  output logic [1:0] wb_sel,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q;
  logic [2:0] alu_op_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) opcode_q <= opcode;
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (opcode == OP_HALT)      state_d = StHalt;
        else if (opcode == OP_JMP)  state_d = StFetch;
        else if (!is_legal(opcode)) state_d = StFetch;
        else                        state_d = StExec;
      end
      StExec: begin
        if (is_rtype(opcode_q) || opcode_q == OP_ADDI)   state_d = StWb;
        else if (opcode_q == OP_LW || opcode_q == OP_SW) state_d = StMem;
        else                                             state_d = StFetch;
      end
      StMem:    state_d = (opcode_q == OP_LW) ? StWb : StFetch;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  alu_op_decode u_alu_op_decode (
    .state    (state_q),
    .opcode_q (opcode_q),
    .alu_op   (alu_op_raw)
  );

  // Reset gates every output, including the FETCH strobes of the reset state.
  assign alu_op = rst_n ? alu_op_raw : ALU_ADD;

  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a_sel = SRC_A_PC;
    alu_src_b_sel = SRC_B_REGB;
    pc_src_sel    = PC_SRC_ALU;
    wb_sel        = WB_ALUOUT;
    instr_done    = 1'b0;
    halted        = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          mem_read      = 1'b1;
          ir_write      = 1'b1;
          pc_write      = 1'b1;
          alu_src_b_sel = SRC_B_ONE;
        end
        StDecode: begin
          alu_src_b_sel = SRC_B_BRANCH;
          if (opcode == OP_JMP) begin
            pc_write   = 1'b1;
            pc_src_sel = PC_SRC_JUMP;
            instr_done = 1'b1;
          end else if (!is_legal(opcode)) begin
            instr_done = 1'b1;
          end
        end
        StExec: begin
          alu_src_a_sel = SRC_A_REGA;
          if (opcode_q == OP_ADDI || opcode_q == OP_LW || opcode_q == OP_SW) begin
            alu_src_b_sel = SRC_B_IMM;
          end else if (opcode_q == OP_BEQ) begin
            pc_src_sel = PC_SRC_ALUOUT;
            pc_write   = zero;
            instr_done = 1'b1;
          end
        end
        StMem: begin
          if (opcode_q == OP_LW) begin
            mem_read = 1'b1;
          end else if (opcode_q == OP_SW) begin
            mem_write  = 1'b1;
            instr_done = 1'b1;
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          wb_sel     = (opcode_q == OP_LW) ? WB_MDR : WB_ALUOUT;
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-cycle output vectors for each instruction class, reset and HALT.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a_sel, alu_src_b_sel, pc_src_sel, wb_sel;
  logic [2:0] alu_op;
  logic       instr_done, halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .alu_src_a_sel (alu_src_a_sel),
    .alu_src_b_sel (alu_src_b_sel),
    .pc_src_sel    (pc_src_sel),
    .wb_sel        (wb_sel),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .halted        (halted)
  );

  // {pcw, irw, mrd, mwr, rwr, src_a, src_b, pc_src, wb, alu_op, done, halted}
  logic [17:0] outs;
  assign outs = {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a_sel,
                 alu_src_b_sel, pc_src_sel, wb_sel, alu_op, instr_done, halted};

  function automatic logic [17:0] mk(input logic pcw, irw, mrd, mwr, rwr, input logic [1:0] sa,
                                     input logic [1:0] sb, ps, wb, input logic [2:0] aop,
                                     input logic done, hlt);
    return {pcw, irw, mrd, mwr, rwr, sa, sb, ps, wb, aop, done, hlt};
  endfunction

  localparam logic [17:0] V_ZERO  = 18'd0;
  localparam logic [17:0] V_FETCH = {5'b11100, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] V_DEC   = {5'b00000, 2'b00, 2'b11, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] V_JMP   = {5'b10000, 2'b00, 2'b11, 2'b10, 2'b00, 3'b000, 2'b10};
  localparam logic [17:0] V_ILL   = {5'b00000, 2'b00, 2'b11, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [17:0] V_EXI   = {5'b00000, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] V_MLW   = {5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [17:0] V_MSW   = {5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [17:0] V_WB    = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [17:0] V_WBLW  = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b10};
  localparam logic [17:0] V_HALT  = 18'd1;

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge; drive, settle, compare, then advance one cycle.
  task automatic step(input string tag, input logic [3:0] op, input logic z,
                      input logic [17:0] exp);
    opcode = op;
    zero   = z;
    #1;
    check_eq(tag, outs, exp);
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 4'h0;
    zero   = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step("reset", 4'h0, 1'b1, V_ZERO);
    rst_n = 1'b1;

    // ADD; garbage opcodes outside DECODE prove opcode_q is used
    step("add_fetch", 4'h8, 1'b0, V_FETCH);
    step("add_dec",   4'h0, 1'b0, V_DEC);
    step("add_exec",  4'hF, 1'b0, mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
    step("add_wb",    4'h5, 1'b0, V_WB);

    step("and_fetch", 4'h0, 1'b0, V_FETCH);
    step("and_dec",   4'h2, 1'b0, V_DEC);
    step("and_exec",  4'h8, 1'b0, mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0));
    step("and_wb",    4'h0, 1'b0, V_WB);

    step("or_fetch",  4'h0, 1'b0, V_FETCH);
    step("or_dec",    4'h3, 1'b0, V_DEC);
    step("or_exec",   4'h0, 1'b0, mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011, 0, 0));
    step("or_wb",     4'h0, 1'b0, V_WB);

    step("addi_fetch", 4'h0, 1'b0, V_FETCH);
    step("addi_dec",   4'h4, 1'b0, V_DEC);
    step("addi_exec",  4'h7, 1'b1, V_EXI);
    step("addi_wb",    4'h5, 1'b0, V_WB);

    step("lw_fetch", 4'h0, 1'b0, V_FETCH);
    step("lw_dec",   4'h5, 1'b0, V_DEC);
    step("lw_exec",  4'h0, 1'b0, V_EXI);
    step("lw_mem",   4'h6, 1'b0, V_MLW);
    step("lw_wb",    4'h0, 1'b0, V_WBLW);

    step("sw_fetch", 4'h0, 1'b0, V_FETCH);
    step("sw_dec",   4'h6, 1'b0, V_DEC);
    step("sw_exec",  4'h5, 1'b0, V_EXI);
    step("sw_mem",   4'h5, 1'b0, V_MSW);

    step("beq1_fetch", 4'h0, 1'b0, V_FETCH);
    step("beq1_dec",   4'h7, 1'b0, V_DEC);
    step("beq1_exec",  4'h0, 1'b1, mk(1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 3'b001, 1, 0));
    step("beq0_fetch", 4'h0, 1'b0, V_FETCH);
    step("beq0_dec",   4'h7, 1'b1, V_DEC);
    step("beq0_exec",  4'h0, 1'b0, mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 3'b001, 1, 0));

    step("jmp_fetch", 4'h0, 1'b0, V_FETCH);
    step("jmp_dec",   4'h8, 1'b0, V_JMP);
    step("ill_fetch", 4'h0, 1'b0, V_FETCH);
    step("ill_dec",   4'hA, 1'b0, V_ILL);

    // SUB abandoned by reset during EXEC
    step("sub_fetch", 4'h0, 1'b0, V_FETCH);
    step("sub_dec",   4'h1, 1'b0, V_DEC);
    opcode = 4'h0;
    #1;
    check_eq("sub_exec", outs, mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));
    rst_n = 1'b0;
    #1;
    check_eq("sub_rst_now", outs, V_ZERO);
    @(negedge clk);
    step("sub_rst_hold", 4'h1, 1'b1, V_ZERO);
    rst_n = 1'b1;
    step("post_rst_fetch", 4'h0, 1'b0, V_FETCH);
    step("post_rst_dec",   4'h0, 1'b0, V_DEC);
    step("post_rst_exec",  4'h0, 1'b0, mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
    step("post_rst_wb",    4'h0, 1'b0, V_WB);

    step("halt_fetch", 4'h0, 1'b0, V_FETCH);
    step("halt_dec",   4'hF, 1'b0, V_DEC);
    for (int i = 0; i < 10; i++) step("halt_hold", 4'h0, 1'b1, V_HALT);
    rst_n = 1'b0;
    #1;
    check_eq("halt_rst", outs, V_ZERO);
    rst_n = 1'b1;
    step("halt_exit_fetch", 4'h0, 1'b0, V_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
